// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit cores.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_t;

    localparam int unsigned UART_BAUD_DIV = 434;
    localparam int unsigned UART_DATA_W   = 8;
    localparam int unsigned UART_CNT_W    = 13;

endpackage

// File: rtl/uart_rx_core_if.sv
// Parallel-side and pin-side signals of the UART receiver.
interface uart_rx_core_if;

    logic                             rx;
    logic [uart_pkg::UART_DATA_W-1:0] data_out;
    logic                             data_valid;
    logic                             frame_err;
    logic                             busy;

    // Master drives the serial line and consumes received bytes
    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    // Slave is the receiver itself
    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Both stages reset to the idle level so no false edge appears after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, LSB-first assembly.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV,  // bit period is BAUD_DIV+1 clocks, >= 4
    parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.slave  bus
);

    localparam logic [UART_CNT_W-1:0] BaudEnd = UART_CNT_W'(BAUD_DIV);
    localparam logic [UART_CNT_W-1:0] HalfEnd = UART_CNT_W'(HALF_DIV);
    localparam logic [3:0]            LastBit = 4'(UART_DATA_W - 1);

    logic                   w_rx_s;
    logic                   r_rx_prev;
    uart_state_t            r_state,    w_state_nxt;
    logic [UART_CNT_W-1:0]  r_baud_cnt, w_baud_cnt_nxt;
    logic [3:0]             r_bit_idx,  w_bit_idx_nxt;
    logic [UART_DATA_W-1:0] r_shift,    w_shift_nxt;
    logic [UART_DATA_W-1:0] r_data,     w_data_nxt;
    logic                   r_valid,    w_valid_nxt;
    logic                   r_ferr,     w_ferr_nxt;

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_s;
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    // Next-state logic: sample at mid-bit, strobes are single-cycle by default
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_data_nxt     = r_data;
        w_valid_nxt    = 1'b0;
        w_ferr_nxt     = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_baud_cnt_nxt = '0;
                // Needs a real 1->0 transition; a line stuck low never re-triggers
                if (r_rx_prev && !w_rx_s) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                if (r_baud_cnt == HalfEnd) begin
                    w_baud_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_state_nxt = StIdle;  // glitch, not a start bit
                    end else begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = StData;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            StData: begin
                if (r_baud_cnt == BaudEnd) begin
                    w_shift_nxt    = {w_rx_s, r_shift[UART_DATA_W-1:1]};
                    w_bit_idx_nxt  = r_bit_idx + 1'b1;
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == LastBit) begin
                        w_state_nxt = StStop;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            StStop: begin
                if (r_baud_cnt == BaudEnd) begin
                    // Back to idle at mid-stop so the next start edge is not missed
                    w_baud_cnt_nxt = '0;
                    w_state_nxt    = StIdle;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at a shortened bit period of 50 clocks.
module tb_uart_rx_core;

    localparam int BAUD = 49;
    localparam int HALF = 24;
    localparam int PER  = BAUD + 1;
    // Pin change -> strobe: 3 edges to enter START, HALF+1 to the start sample,
    // nine bit periods to the stop sample, then the strobe register.
    localparam int LAT  = 4 + HALF + 9 * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_core_if u_if ();

    uart_rx_core #(
        .BAUD_DIV (BAUD),
        .HALF_DIV (HALF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] vq[$];
    int         vt[$];
    int         ft[$];
    int         multi   = 0;
    int         overlap = 0;
    int         stray   = 0;
    logic [7:0] last_data = 8'h00;
    bit         prev_v = 1'b0;
    bit         prev_f = 1'b0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Records every strobe and any protocol misbehaviour on the outputs
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_data = u_if.data_out;
            prev_v    = 1'b0;
            prev_f    = 1'b0;
        end else begin
            if (u_if.data_valid) begin
                vq.push_back(u_if.data_out);
                vt.push_back(cyc);
            end
            if (u_if.frame_err) ft.push_back(cyc);
            if (u_if.data_valid && u_if.frame_err) overlap++;
            if ((u_if.data_valid && prev_v) || (u_if.frame_err && prev_f)) multi++;
            if (!u_if.data_valid && u_if.data_out !== last_data) stray++;
            last_data = u_if.data_out;
            prev_v    = u_if.data_valid;
            prev_f    = u_if.frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Call at a negedge; returns at a negedge with the line at the stop level
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per,
                              output int t0);
        u_if.rx = 1'b0;
        t0 = cyc;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            repeat (per) @(negedge clk);
        end
        u_if.rx = stop_bit;
        repeat (per) @(negedge clk);
    endtask

    task automatic idle(input int n);
        u_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        u_if.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (u_if.data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", u_if.data_out);
        else passed++;
        checks++;
        if (u_if.data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", u_if.data_valid);
        else passed++;
        checks++;
        if (u_if.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", u_if.frame_err);
        else passed++;
        checks++;
        if (u_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u_if.busy);
        else passed++;
        rst = 1'b0;
        idle(10);
        checks++;
        if (u_if.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", u_if.busy);
        else passed++;
    endtask

    task automatic test_single();
        int t0;
        int n0 = vq.size();
        int f0 = ft.size();
        send_frame(8'hA5, 1'b1, PER, t0);
        idle(10);
        checks++;
        if (vq.size() !== n0 + 1) $display("FAIL single_count: got %0d want %0d", vq.size(), n0 + 1);
        else passed++;
        checks++;
        if (vq[n0] !== 8'hA5) $display("FAIL single_data: got %h want a5", vq[n0]);
        else passed++;
        checks++;
        if (vt[n0] !== t0 + LAT) $display("FAIL single_latency: got %0d want %0d", vt[n0] - t0, LAT);
        else passed++;
        checks++;
        if (ft.size() !== f0) $display("FAIL single_ferr: got %0d want %0d", ft.size(), f0);
        else passed++;
        checks++;
        if (u_if.data_out !== 8'hA5) $display("FAIL single_hold: got %h want a5", u_if.data_out);
        else passed++;
    endtask

    task automatic test_glitch();
        int n0 = vq.size();
        int f0 = ft.size();
        int t0;
        u_if.rx = 1'b0;
        t0 = cyc;
        repeat (10) @(negedge clk);
        u_if.rx = 1'b1;
        while (cyc < t0 + HALF + 3) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b1) $display("FAIL glitch_busy_high: got %b want 1", u_if.busy);
        else passed++;
        @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0) $display("FAIL glitch_busy_low: got %b want 0", u_if.busy);
        else passed++;
        idle(PER * 12);
        checks++;
        if (vq.size() + ft.size() !== n0 + f0)
            $display("FAIL glitch_strobe: got %0d strobes want %0d", vq.size() + ft.size(), n0 + f0);
        else passed++;
    endtask

    task automatic test_frame_err();
        int t0;
        int t1;
        int n0 = vq.size();
        int f0 = ft.size();
        send_frame(8'h11, 1'b1, PER, t0);
        idle(20);
        send_frame(8'h3C, 1'b0, PER, t1);
        repeat (2000) @(negedge clk);  // line stays low after the bad stop bit
        checks++;
        if (vq.size() !== n0 + 1) $display("FAIL ferr_valid_count: got %0d want %0d", vq.size(), n0 + 1);
        else passed++;
        checks++;
        if (vq[n0] !== 8'h11) $display("FAIL ferr_prior_data: got %h want 11", vq[n0]);
        else passed++;
        checks++;
        if (ft.size() !== f0 + 1) $display("FAIL ferr_count: got %0d want %0d", ft.size(), f0 + 1);
        else passed++;
        checks++;
        if (ft[f0] !== t1 + LAT) $display("FAIL ferr_latency: got %0d want %0d", ft[f0] - t1, LAT);
        else passed++;
        checks++;
        if (u_if.data_out !== 8'h11) $display("FAIL ferr_hold: got %h want 11", u_if.data_out);
        else passed++;
        checks++;
        if (u_if.busy !== 1'b0) $display("FAIL ferr_low_line_busy: got %b want 0", u_if.busy);
        else passed++;
        idle(PER * 2);
        send_frame(8'hA5, 1'b1, PER, t0);
        idle(10);
        checks++;
        if (vq.size() !== n0 + 2 || vq[n0 + 1] !== 8'hA5)
            $display("FAIL ferr_recover: got %0d/%h want %0d/a5", vq.size(), vq[n0 + 1], n0 + 2);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int n0 = vq.size();
        send_frame(8'h00, 1'b1, PER, t0);
        send_frame(8'hFF, 1'b1, PER, t1);
        idle(10);
        checks++;
        if (vq.size() !== n0 + 2) $display("FAIL b2b_count: got %0d want %0d", vq.size(), n0 + 2);
        else passed++;
        checks++;
        if (vq[n0] !== 8'h00 || vq[n0 + 1] !== 8'hFF)
            $display("FAIL b2b_data: got %h,%h want 00,ff", vq[n0], vq[n0 + 1]);
        else passed++;
        checks++;
        if (vt[n0 + 1] - vt[n0] !== 10 * PER)
            $display("FAIL b2b_spacing: got %0d want %0d", vt[n0 + 1] - vt[n0], 10 * PER);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int t0;
        int n0;
        logic [7:0] b = 8'h5A;
        n0 = vq.size();
        u_if.rx = 1'b0;
        repeat (PER) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = b[i];
            repeat (PER) @(negedge clk);
        end
        u_if.rx = b[4];
        repeat (PER / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (u_if.data_out !== 8'h00) $display("FAIL midrst_data: got %h want 00", u_if.data_out);
        else passed++;
        checks++;
        if ({u_if.data_valid, u_if.frame_err, u_if.busy} !== 3'b000)
            $display("FAIL midrst_flags: got %b want 000",
                     {u_if.data_valid, u_if.frame_err, u_if.busy});
        else passed++;
        repeat (5) @(negedge clk);
        u_if.rx = 1'b1;
        rst = 1'b0;
        idle(PER * 12);
        checks++;
        if (vq.size() !== n0) $display("FAIL midrst_no_strobe: got %0d want %0d", vq.size(), n0);
        else passed++;
        send_frame(8'hC3, 1'b1, PER, t0);
        idle(10);
        checks++;
        if (vq.size() !== n0 + 1 || vq[n0] !== 8'hC3)
            $display("FAIL midrst_next: got %0d/%h want %0d/c3", vq.size(), vq[n0], n0 + 1);
        else passed++;
    endtask

    task automatic test_tolerance();
        int t0;
        int n0 = vq.size();
        int f0 = ft.size();
        send_frame(8'h96, 1'b1, PER - 1, t0);
        idle(30);
        send_frame(8'h96, 1'b1, PER + 1, t0);
        idle(30);
        checks++;
        if (vq.size() !== n0 + 2) $display("FAIL tol_count: got %0d want %0d", vq.size(), n0 + 2);
        else passed++;
        checks++;
        if (vq[n0] !== 8'h96) $display("FAIL tol_fast: got %h want 96", vq[n0]);
        else passed++;
        checks++;
        if (vq[n0 + 1] !== 8'h96) $display("FAIL tol_slow: got %h want 96", vq[n0 + 1]);
        else passed++;
        checks++;
        if (ft.size() !== f0) $display("FAIL tol_ferr: got %0d want %0d", ft.size(), f0);
        else passed++;
    endtask

    // Back-to-back stream from a behavioural transmitter
    task automatic test_loopback();
        int t0;
        int n0 = vq.size();
        int f0 = ft.size();
        logic [7:0] b;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 53 + 7);
            send_frame(b, 1'b1, PER, t0);
        end
        idle(20);
        checks++;
        if (vq.size() !== n0 + 32) $display("FAIL loop_count: got %0d want %0d", vq.size(), n0 + 32);
        else passed++;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 53 + 7);
            checks++;
            if (vq[n0 + i] !== b) $display("FAIL loop_byte%0d: got %h want %h", i, vq[n0 + i], b);
            else passed++;
        end
        checks++;
        if (ft.size() !== f0) $display("FAIL loop_ferr: got %0d want %0d", ft.size(), f0);
        else passed++;
    endtask

    task automatic test_invariants();
        checks++;
        if (multi !== 0) $display("FAIL strobe_width: got %0d long pulses want 0", multi);
        else passed++;
        checks++;
        if (overlap !== 0) $display("FAIL strobe_exclusive: got %0d overlaps want 0", overlap);
        else passed++;
        checks++;
        if (stray !== 0) $display("FAIL data_stable: got %0d unstrobed changes want 0", stray);
        else passed++;
    endtask

    initial begin
        u_if.rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_tolerance();
        test_loopback();
        test_invariants();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
